// File: rtl/keypad_lock_ctrl.sv
// Keypad code lock: one-hot keys in, BCD display nibbles, status flags and buzzer out.
// Wrong-code lockout with a BCD countdown and a distinct tone per event class.
module keypad_lock_ctrl #(
    parameter int                  DIGITS    = 3,
    parameter logic [4*DIGITS-1:0] PASSWORD  = 'h246,
    parameter int                  MAX_TRIES = 3,
    parameter int                  LOCK_SECS = 20,
    parameter int                  CLK_HZ    = 50_000_000,
    parameter int                  CLICK_HP  = 50_000,
    parameter int                  OK_HP     = 25_000,
    parameter int                  FAIL_HP   = 100_000
) (
    input  logic                           clk,
    input  logic                           RSTn,
    input  logic [15:0]                    onehot,
    output logic [4*DIGITS-1:0]            disp,
    output logic [$clog2(DIGITS+1)-1:0]    entered,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries,
    output logic                           unlocked,
    output logic                           lockout,
    output logic [7:0]                     secs_left,
    output logic                           buzzer
);
    localparam int EW = $clog2(DIGITS+1);
    localparam int TW = $clog2(MAX_TRIES+1);
    localparam int CW = $clog2(CLK_HZ) + 1;

    localparam logic [1:0] S_ENTRY = 2'd0, S_OPEN = 2'd1, S_LOCK = 2'd2;
    localparam logic [1:0] T_NONE = 2'd0, T_CLICK = 2'd1, T_OK = 2'd2, T_FAIL = 2'd3;

    localparam logic [7:0]          LOCK_BCD = 8'(((LOCK_SECS / 10) << 4) | (LOCK_SECS % 10));
    localparam logic [4*DIGITS-1:0] BLANK    = '1;
    localparam logic [4*DIGITS-1:0] ALL_A    = {DIGITS{4'hA}};
    localparam logic [CW-1:0]       PRE_MAX  = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0]       GAP_LO   = CW'(CLK_HZ / 10);
    localparam logic [CW-1:0]       GAP_HI   = CW'(CLK_HZ / 5);

    logic [1:0]          state, state_n;
    logic [15:0]         last_key;
    logic [4*DIGITS-1:0] disp_n;
    logic [EW-1:0]       entered_n;
    logic [TW-1:0]       tries_n, tries_inc;
    logic [7:0]          secs_n, secs_dec;
    logic [CW-1:0]       presc, presc_n;
    logic [1:0]          req;

    logic                key_ev, is_dig, k_enter, k_clear, k_reset;
    logic [3:0]          key_dig;
    logic [4*DIGITS+3:0] shift_w;
    logic [4*DIGITS+7:0] lock_w;

    // Edge-detect on the raw code; a held key produces exactly one event.
    assign key_ev = (onehot != last_key) && (onehot != 16'd0) && ((onehot & (onehot - 16'd1)) == 16'd0);

    always_comb begin
        is_dig  = 1'b1;
        key_dig = 4'd0;
        k_enter = 1'b0;
        k_clear = 1'b0;
        k_reset = 1'b0;
        case (onehot)
            16'h0008: key_dig = 4'd0;
            16'h0080: key_dig = 4'd1;
            16'h0040: key_dig = 4'd2;
            16'h0020: key_dig = 4'd3;
            16'h0800: key_dig = 4'd4;
            16'h0400: key_dig = 4'd5;
            16'h0200: key_dig = 4'd6;
            16'h8000: key_dig = 4'd7;
            16'h4000: key_dig = 4'd8;
            16'h2000: key_dig = 4'd9;
            16'h0001: begin is_dig = 1'b0; k_enter = 1'b1; end
            16'h1000: begin is_dig = 1'b0; k_clear = 1'b1; end
            16'h0100: begin is_dig = 1'b0; k_reset = 1'b1; end
            default:  is_dig = 1'b0;
        endcase
    end

    assign shift_w   = {disp, key_dig};
    assign tries_inc = tries + TW'(1);
    assign secs_dec  = (secs_left[3:0] == 4'd0) ? {secs_left[7:4] - 4'd1, 4'd9}
                                                : {secs_left[7:4], secs_left[3:0] - 4'd1};
    assign lock_w    = {BLANK, secs_n};

    always_comb begin
        state_n   = state;
        disp_n    = disp;
        entered_n = entered;
        tries_n   = tries;
        secs_n    = secs_left;
        presc_n   = presc;
        req       = T_NONE;
        case (state)
            S_ENTRY: if (key_ev) begin
                if (is_dig && entered != EW'(DIGITS)) begin
                    disp_n    = shift_w[4*DIGITS-1:0];
                    entered_n = entered + EW'(1);
                    req       = T_CLICK;
                end else if (k_clear || k_reset) begin
                    disp_n    = BLANK;
                    entered_n = '0;
                    req       = T_CLICK;
                    if (k_reset) tries_n = '0;
                end else if (k_enter && entered == EW'(DIGITS)) begin
                    entered_n = '0;
                    if (disp == PASSWORD) begin
                        state_n = S_OPEN;
                        tries_n = '0;
                        disp_n  = ALL_A;
                        req     = T_OK;
                    end else begin
                        req = T_FAIL;
                        if (tries_inc == TW'(MAX_TRIES)) begin
                            state_n = S_LOCK;
                            tries_n = '0;
                            secs_n  = LOCK_BCD;
                            presc_n = '0;
                            disp_n  = lock_w[4*DIGITS-1:0];
                        end else begin
                            tries_n = tries_inc;
                            disp_n  = BLANK;
                        end
                    end
                end
            end
            S_OPEN: if (key_ev && (k_enter || k_reset)) begin
                state_n   = S_ENTRY;
                disp_n    = BLANK;
                entered_n = '0;
                req       = T_CLICK;
            end
            S_LOCK: begin
                if (presc == PRE_MAX) begin
                    presc_n = '0;
                    if (secs_left == 8'h01) begin
                        state_n = S_ENTRY;
                        secs_n  = 8'h00;
                        disp_n  = BLANK;
                    end else begin
                        secs_n = secs_dec;
                        disp_n = lock_w[4*DIGITS-1:0];
                    end
                end else begin
                    presc_n = presc + CW'(1);
                end
            end
            default: state_n = S_ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state     <= S_ENTRY;
            last_key  <= 16'd0;
            disp      <= BLANK;
            entered   <= '0;
            tries     <= '0;
            secs_left <= 8'h00;
            presc     <= '0;
        end else begin
            state     <= state_n;
            last_key  <= onehot;
            disp      <= disp_n;
            entered   <= entered_n;
            tries     <= tries_n;
            secs_left <= secs_n;
            presc     <= presc_n;
        end
    end

    assign unlocked = (state == S_OPEN);
    assign lockout  = (state == S_LOCK);

    logic [1:0]    tone;
    logic [CW-1:0] tcnt, hcnt, tone_len, tone_hp;
    logic          sq;

    always_comb begin
        tone_len = CW'(CLK_HZ / 5);
        tone_hp  = CW'(CLICK_HP - 1);
        case (tone)
            T_OK:    begin tone_len = CW'(3 * CLK_HZ / 5);  tone_hp = CW'(OK_HP - 1);   end
            T_FAIL:  begin tone_len = CW'(3 * CLK_HZ / 10); tone_hp = CW'(FAIL_HP - 1); end
            default: ;
        endcase
    end

    // A new request always restarts the tone, even over one already playing.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            tone <= T_NONE;
            tcnt <= '0;
            hcnt <= '0;
            sq   <= 1'b0;
        end else if (req != T_NONE) begin
            tone <= req;
            tcnt <= '0;
            hcnt <= '0;
            sq   <= 1'b1;
        end else if (tone != T_NONE) begin
            if (tcnt == tone_len - CW'(1)) begin
                tone <= T_NONE;
                sq   <= 1'b0;
            end else begin
                tcnt <= tcnt + CW'(1);
                if (hcnt == tone_hp) begin
                    hcnt <= '0;
                    sq   <= ~sq;
                end else begin
                    hcnt <= hcnt + CW'(1);
                end
            end
        end
    end

    // Failure tone is two bursts separated by a silent gap.
    assign buzzer = (tone != T_NONE) && sq && !(tone == T_FAIL && tcnt >= GAP_LO && tcnt < GAP_HI);
endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl: unlock, key hold, lockout countdown,
// ignored keys and asynchronous reset mid-tone / mid-countdown.
module tb_keypad_lock_ctrl;
    logic        clk = 1'b0;
    logic        RSTn;
    logic [15:0] onehot;
    logic [11:0] disp;
    logic [1:0]  entered;
    logic [1:0]  tries;
    logic        unlocked, lockout, buzzer;
    logic [7:0]  secs_left;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [15:0] K1 = 16'h0080, K2 = 16'h0040, K3 = 16'h0020, K4 = 16'h0800;
    localparam logic [15:0] K6 = 16'h0200, K7 = 16'h8000, K9 = 16'h2000;
    localparam logic [15:0] ENT = 16'h0001, CLR = 16'h1000, RST = 16'h0100;

    keypad_lock_ctrl #(
        .DIGITS(3), .PASSWORD(12'h246), .MAX_TRIES(3), .LOCK_SECS(12), .CLK_HZ(1000),
        .CLICK_HP(10), .OK_HP(5), .FAIL_HP(20)
    ) dut (
        .clk(clk), .RSTn(RSTn), .onehot(onehot), .disp(disp), .entered(entered),
        .tries(tries), .unlocked(unlocked), .lockout(lockout), .secs_left(secs_left),
        .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Returns on the falling edge right after the edge that registered the key.
    task automatic press(input logic [15:0] key);
        @(negedge clk) onehot = key;
        @(negedge clk) onehot = 16'd0;
    endtask

    task automatic enter_code(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        press(a); press(b); press(c); press(ENT);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_disp"}, disp, 12'hFFF);
        chk({tag, "_entered"}, entered, 0);
        chk({tag, "_tries"}, tries, 0);
        chk({tag, "_unlocked"}, unlocked, 0);
        chk({tag, "_lockout"}, lockout, 0);
        chk({tag, "_secs"}, secs_left, 0);
        chk({tag, "_buzzer"}, buzzer, 0);
    endtask

    initial begin
        int bad;
        logic exp_bz;
        RSTn   = 1'b0;
        onehot = 16'd0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        RSTn = 1'b1;
        @(negedge clk);

        // Correct code unlocks; OK tone half-period 5 for 600 cycles.
        press(K2); chk("click_start", buzzer, 1);
        press(K4); press(K6); chk("disp_246", disp, 12'h246);
        press(ENT);
        chk("open_disp", disp, 12'hAAA);
        chk("open_unl", unlocked, 1);
        chk("open_tries", tries, 0);
        bad = 0;
        for (int k = 0; k < 620; k++) begin
            exp_bz = (k < 600) && ((k / 5) % 2 == 0);
            if (buzzer !== exp_bz) bad++;
            @(negedge clk);
        end
        chk("ok_tone_shape", bad, 0);
        press(K2);
        chk("open_ign_disp", disp, 12'hAAA);
        chk("open_ign_bz", buzzer, 0);
        press(ENT);
        chk("relock_disp", disp, 12'hFFF);
        chk("relock_unl", unlocked, 0);

        // Holding a key registers one digit.
        @(negedge clk) onehot = K2;
        repeat (50) @(negedge clk);
        chk("hold_entered", entered, 1);
        onehot = 16'd0;
        press(K2);
        chk("hold_disp", disp, 12'hF22);
        chk("hold_entered2", entered, 2);
        press(CLR);
        chk("clear_disp", disp, 12'hFFF);
        chk("clear_entered", entered, 0);

        // Wrong codes: fail tone shape, then lockout.
        enter_code(K1, K2, K3);
        chk("fail1_tries", tries, 1);
        chk("fail1_disp", disp, 12'hFFF);
        chk("fail1_entered", entered, 0);
        bad = 0;
        for (int k = 0; k < 320; k++) begin
            exp_bz = (k < 300) && !(k >= 100 && k < 200) && ((k / 20) % 2 == 0);
            if (buzzer !== exp_bz) bad++;
            @(negedge clk);
        end
        chk("fail_tone_shape", bad, 0);
        enter_code(K1, K2, K3);
        chk("fail2_tries", tries, 2);
        enter_code(K1, K2, K3);
        chk("lock_flag", lockout, 1);
        chk("lock_secs", secs_left, 8'h12);
        chk("lock_tries", tries, 0);
        chk("lock_disp", disp, 12'hF12);
        repeat (999) @(negedge clk);
        chk("lock_999", secs_left, 8'h12);
        @(negedge clk);
        chk("lock_1000", secs_left, 8'h11);
        // Keys during lockout are ignored.
        press(RST); press(K2);
        chk("lk_ign_disp", disp, 12'hF11);
        chk("lk_ign_entered", entered, 0);
        chk("lk_ign_flag", lockout, 1);
        chk("lk_ign_bz", buzzer, 0);
        repeat (996) @(negedge clk);
        chk("lock_2000", secs_left, 8'h10);
        repeat (1000) @(negedge clk);
        chk("lock_3000", secs_left, 8'h09);
        chk("lock_3000_disp", disp, 12'hF09);
        repeat (8999) @(negedge clk);
        chk("lock_11999", secs_left, 8'h01);
        chk("lock_11999_flag", lockout, 1);
        @(negedge clk);
        chk("lock_end_flag", lockout, 0);
        chk("lock_end_secs", secs_left, 8'h00);
        chk("lock_end_disp", disp, 12'hFFF);

        // Extra digit ignored, multi-bit code ignored, RESET key clears tries.
        press(K7); press(K7); press(K7);
        chk("d777_disp", disp, 12'h777);
        chk("d777_entered", entered, 3);
        repeat (250) @(negedge clk);
        press(K9);
        chk("d4_disp", disp, 12'h777);
        chk("d4_noclick", buzzer, 0);
        press(ENT);
        chk("d777_fail", tries, 1);
        press(K2);
        press(16'h0041);
        chk("multi_disp", disp, 12'hFF2);
        chk("multi_entered", entered, 1);
        chk("multi_tries", tries, 1);
        press(RST);
        chk("rstkey_tries", tries, 0);
        chk("rstkey_entered", entered, 0);
        chk("rstkey_disp", disp, 12'hFFF);

        // Asynchronous reset mid fail tone.
        enter_code(K1, K2, K3);
        repeat (10) @(negedge clk);
        chk("pre_rst_bz", buzzer, 1);
        RSTn = 1'b0;
        #1;
        chk_reset_vals("rst_tone");
        @(negedge clk) RSTn = 1'b1;

        // Asynchronous reset mid countdown.
        enter_code(K1, K2, K3);
        enter_code(K1, K2, K3);
        enter_code(K1, K2, K3);
        repeat (1500) @(negedge clk);
        chk("pre_rst_secs", secs_left, 8'h11);
        RSTn = 1'b0;
        #1;
        chk_reset_vals("rst_lock");
        @(negedge clk) RSTn = 1'b1;
        press(K2);
        chk("post_rst_disp", disp, 12'hFF2);
        chk("post_rst_entered", entered, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
